// File: rtl/hilo_mdu.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair for the EX stage.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply path; divides stay iterative.
module hilo_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Abort,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteDataIn,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] ReadDataHi,
  output logic [WIDTH-1:0] ReadDataLo
);

  localparam int unsigned DW = 2 * WIDTH;

  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateType;

  stateType         state, stateNext;
  logic [2:0]       opQ;
  logic [DW-1:0]    acc;
  logic [DW-1:0]    snapshot;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] dividendQ;
  logic             negResult;
  logic             negRem;
  logic             divZero;
  logic [CNT_W-1:0] count;

  logic             opValid, opIsDiv, opSigned, startValid;
  logic             loadOp, runStep, commit;
  logic [WIDTH-1:0] magA, magB;

  // Decode of the incoming op and operand magnitudes
  assign opValid    = !(Op[2] && Op[1]);
  assign opIsDiv    = (Op[2:1] == 2'b01);
  assign opSigned   = (Op != OP_MULTU) && (Op != OP_DIVU);
  assign magA       = (opSigned && OperandA[WIDTH-1]) ? -OperandA : OperandA;
  assign magB       = (opSigned && OperandB[WIDTH-1]) ? -OperandB : OperandB;
  assign startValid = Start && !Abort && opValid;

  // Next-state and control strobes
  always_comb begin
    stateNext = state;
    loadOp    = 1'b0;
    runStep   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (startValid) begin
          loadOp    = 1'b1;
          stateNext = (FAST_MUL && !opIsDiv) ? FIX : RUN;
        end
      end
      RUN: begin
        if (Abort) begin
          stateNext = IDLE;
        end else begin
          runStep = 1'b1;
          if (count == CNT_W'(WIDTH - 1)) stateNext = FIX;
        end
      end
      FIX: begin
        stateNext = IDLE;
        commit    = !Abort;
      end
      default: stateNext = IDLE;
    endcase
  end

  logic [WIDTH:0]  mulSum, divShift, divTrial;
  logic [DW-1:0]   stepNext;

  // One shift-add (multiply) or restoring-subtract (divide) iteration on acc
  always_comb begin
    mulSum   = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
    divShift = {acc[DW-1:WIDTH], acc[WIDTH-1]};
    divTrial = divShift - {1'b0, mag};
    if (opQ[2:1] == 2'b01) begin
      stepNext = divTrial[WIDTH] ? {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      stepNext = {mulSum, acc[WIDTH-1:1]};
    end
  end

  logic [WIDTH-1:0] quo, rem;
  logic [DW-1:0]    prod, result;

  // Sign correction and accumulate; acc holds {remainder, quotient} for divides
  always_comb begin
    prod = negResult ? -acc : acc;
    quo  = negResult ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = negRem ? -acc[DW-1:WIDTH] : acc[DW-1:WIDTH];
    case (opQ)
      OP_DIV, OP_DIVU: result = divZero ? {dividendQ, {WIDTH{1'b1}}} : {rem, quo};
      OP_MADD:         result = snapshot + prod;
      OP_MSUB:         result = snapshot - prod;
      default:         result = prod;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state      <= IDLE;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      DivByZero  <= 1'b0;
      ReadDataHi <= '0;
      ReadDataLo <= '0;
      opQ        <= '0;
      acc        <= '0;
      snapshot   <= '0;
      mag        <= '0;
      dividendQ  <= '0;
      negResult  <= 1'b0;
      negRem     <= 1'b0;
      divZero    <= 1'b0;
      count      <= '0;
    end else begin
      state     <= stateNext;
      Busy      <= (stateNext != IDLE);
      Done      <= commit;
      DivByZero <= commit && divZero;

      if (loadOp) begin
        opQ       <= Op;
        snapshot  <= {ReadDataHi, ReadDataLo};
        dividendQ <= OperandA;
        negResult <= opSigned && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
        negRem    <= opSigned && OperandA[WIDTH-1];
        divZero   <= opIsDiv && (OperandB == '0);
        count     <= '0;
        if (opIsDiv) begin
          mag <= magB;
          acc <= {{WIDTH{1'b0}}, magA};
        end else begin
          mag <= magA;
`ifdef MDU_FAST_MUL_EN
          acc <= DW'(magA) * DW'(magB);
`else
          acc <= {{WIDTH{1'b0}}, magB};
`endif
        end
      end else if (runStep) begin
        count <= count + CNT_W'(1);
        acc   <= stepNext;
      end

      // Op results win; mthi/mtlo only land while idle with no Start
      if (commit) begin
        {ReadDataHi, ReadDataLo} <= result;
      end else if (state == IDLE && !Start) begin
        if (HiWrite) ReadDataHi <= WriteDataIn;
        if (LoWrite) ReadDataLo <= WriteDataIn;
      end
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed cases plus randomized ops against an arithmetic model.
module tb_hilo_mdu;

  localparam int unsigned W = 32;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Start = 1'b0;
  logic [2:0]   Op = 3'b000;
  logic [W-1:0] OperandA = '0;
  logic [W-1:0] OperandB = '0;
  logic         Abort = 1'b0;
  logic         HiWrite = 1'b0;
  logic         LoWrite = 1'b0;
  logic [W-1:0] WriteDataIn = '0;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] ReadDataHi, ReadDataLo;

  always #5 Clk = ~Clk;

  hilo_mdu #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .Abort(Abort),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteDataIn(WriteDataIn),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .ReadDataHi(ReadDataHi), .ReadDataLo(ReadDataLo)
  );

  int nChecks = 0;
  int nPass = 0;
  logic [W-1:0] mHi = '0;
  logic [W-1:0] mLo = '0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference results straight from the arithmetic definition of each op
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] hi, input logic [W-1:0] lo,
                                output logic [W-1:0] rHi, output logic [W-1:0] rLo, output logic dbz);
    longint sp;
    logic [63:0] up, hl;
    int sa, sb;
    dbz = 1'b0;
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = {32'b0, a} * {32'b0, b};
    hl  = {hi, lo};
    sa  = $signed(a);
    sb  = $signed(b);
    rHi = hi;
    rLo = lo;
    case (op)
      3'd0: {rHi, rLo} = 64'(sp);
      3'd1: {rHi, rLo} = up;
      3'd4: {rHi, rLo} = hl + 64'(sp);
      3'd5: {rHi, rLo} = hl - 64'(sp);
      3'd2: begin
        if (b == 0) begin
          rHi = a; rLo = '1; dbz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rHi = '0; rLo = 32'h8000_0000;
        end else begin
          rLo = 32'(sa / sb);
          rHi = 32'(sa % sb);
        end
      end
      3'd3: begin
        if (b == 0) begin
          rHi = a; rLo = '1; dbz = 1'b1;
        end else begin
          rLo = a / b;
          rHi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op);
`ifdef MDU_FAST_MUL_EN
    if (op[2:1] != 2'b01) return 1;
`endif
    return int'(W + 1);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Count busy cycles (optionally poking a second Start mid-op), then check the committed result
  task automatic waitResult(input string tag, input int expCycles, input logic [W-1:0] eHi,
                            input logic [W-1:0] eLo, input logic eDbz, input int pokeAt);
    int n = 0;
    bit early = 1'b0;
    while (Busy && n < 200) begin
      if (Done) early = 1'b1;
      if (n == pokeAt) begin
        Start = 1'b1; Op = 3'd0; OperandA = $urandom; OperandB = $urandom;
      end else begin
        Start = 1'b0;
      end
      n++;
      tick();
    end
    Start = 1'b0;
    checkEq({tag, ".busyCycles"}, 64'(n), 64'(expCycles));
    checkEq({tag, ".done"}, {62'b0, early, Done}, 64'b01);
    checkEq({tag, ".dbz"}, 64'(DivByZero), 64'(eDbz));
    checkEq({tag, ".hilo"}, {ReadDataHi, ReadDataLo}, {eHi, eLo});
    mHi = eHi;
    mLo = eLo;
    tick();
    checkEq({tag, ".idle"}, {61'b0, Busy, Done, DivByZero}, 64'b0);
  endtask

  task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag, input int pokeAt);
    logic [W-1:0] eHi, eLo;
    logic eDbz;
    model(op, a, b, mHi, mLo, eHi, eLo, eDbz);
    Op = op; OperandA = a; OperandB = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    waitResult(tag, latency(op), eHi, eLo, eDbz, pokeAt);
  endtask

  task automatic writeHiLo(input logic hw, input logic lw, input logic [W-1:0] d);
    HiWrite = hw; LoWrite = lw; WriteDataIn = d;
    tick();
    HiWrite = 1'b0; LoWrite = 1'b0;
    if (hw) mHi = d;
    if (lw) mLo = d;
    checkEq("mtHiLo", {ReadDataHi, ReadDataLo}, {mHi, mLo});
  endtask

  task automatic reservedStart(input logic [2:0] op);
    Op = op; OperandA = $urandom; OperandB = $urandom; Start = 1'b1;
    tick();
    Start = 1'b0;
    checkEq("reserved.busy", 64'(Busy), 64'b0);
    tick();
    checkEq("reserved.state", {Busy, Done, ReadDataHi, ReadDataLo}, {2'b00, mHi, mLo});
  endtask

  initial begin
    bit sawDone;
    logic [2:0] op;
    logic [W-1:0] a, b;
    int sel;

    Rst = 1'b0;
    tick();
    tick();
    checkEq("reset", {Busy, Done, DivByZero, ReadDataHi, ReadDataLo}, 67'b0);
    Rst = 1'b1;
    tick();

    runOp(3'd0, 32'hFFFF_FFFD, 32'd7, "mult", -1);
    checkEq("multConst", {ReadDataHi, ReadDataLo}, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp(3'd3, 32'd100, 32'd7, "divu", -1);
    checkEq("divuConst", {ReadDataHi, ReadDataLo}, {32'd2, 32'd14});
    runOp(3'd2, 32'hFFFF_FFF9, 32'd2, "divNeg", -1);
    checkEq("divNegConst", {ReadDataHi, ReadDataLo}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "divOvf", -1);
    checkEq("divOvfConst", {ReadDataHi, ReadDataLo}, 64'h0000_0000_8000_0000);

    writeHiLo(1'b1, 1'b0, 32'd0);
    writeHiLo(1'b0, 1'b1, 32'd10);
    runOp(3'd4, 32'd3, 32'd4, "madd", -1);
    checkEq("maddConst", {ReadDataHi, ReadDataLo}, {32'd0, 32'd22});
    runOp(3'd5, 32'd5, 32'd5, "msub", -1);
    checkEq("msubConst", {ReadDataHi, ReadDataLo}, 64'hFFFF_FFFF_FFFF_FFFD);

    runOp(3'd2, 32'd5, 32'd0, "divZero", -1);
    checkEq("divZeroConst", {ReadDataHi, ReadDataLo}, {32'd5, 32'hFFFF_FFFF});

    runOp(3'd1, 32'hFFFF_FFFF, 32'd2, "multu", -1);
    checkEq("multuConst", {ReadDataHi, ReadDataLo}, {32'd1, 32'hFFFF_FFFE});

    // Abort mid-op leaves HI/LO untouched and never pulses Done
    writeHiLo(1'b1, 1'b0, 32'd1);
    writeHiLo(1'b0, 1'b1, 32'd2);
`ifdef MDU_FAST_MUL_EN
    Op = 3'd2;
`else
    Op = 3'd0;
`endif
    OperandA = 32'd1234; OperandB = 32'd77; Start = 1'b1;
    tick();
    Start = 1'b0;
    sawDone = 1'b0;
    repeat (10) begin
      if (Done) sawDone = 1'b1;
      tick();
    end
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    checkEq("abort.busy", 64'(Busy), 64'b0);
    repeat (3) begin
      if (Done) sawDone = 1'b1;
      tick();
    end
    checkEq("abort.noDone", 64'(sawDone), 64'b0);
    checkEq("abort.hilo", {ReadDataHi, ReadDataLo}, {32'd1, 32'd2});

    Op = 3'd0; OperandA = 32'd9; OperandB = 32'd9; Start = 1'b1; Abort = 1'b1;
    tick();
    Start = 1'b0; Abort = 1'b0;
    checkEq("abortStart.busy", 64'(Busy), 64'b0);

    runOp(3'd3, 32'd100, 32'd7, "startWhileBusy", 5);

    reservedStart(3'd6);
    reservedStart(3'd7);

    // Synchronous reset while a divide is in flight
    Op = 3'd2; OperandA = 32'd1000; OperandB = 32'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (5) tick();
    Rst = 1'b0;
    tick();
    checkEq("midReset", {Busy, Done, DivByZero, ReadDataHi, ReadDataLo}, 67'b0);
    Rst = 1'b1;
    mHi = '0;
    mLo = '0;
    tick();

    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) writeHiLo(1'($urandom), 1'($urandom), $urandom);
      if (op[2] && op[1]) reservedStart(op);
      else runOp(op, a, b, $sformatf("rand%0d", i), -1);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
